// File: rtl/rnn_sequencer_pkg.sv
// Shared types for the rnn sequencer: FSM states and the accelerator
// register map it drives.
package rnn_seq_pkg;

  typedef logic [2:0] rnn_addr_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_EMB,
    ST_WR_START,
    ST_GAP,
    ST_WAIT_LOAD,
    ST_WR_DENSE,
    ST_WAIT_VALID,
    ST_RD_RESULT,
    ST_WAIT_CLR
  } seq_state_e;

  // Write and read views share addresses; status bits live in bit 0.
  localparam rnn_addr_t RNN_ADDR_START      = 3'd0;
  localparam rnn_addr_t RNN_ADDR_INPUT      = 3'd1;
  localparam rnn_addr_t RNN_ADDR_LOAD_STAT  = 3'd1;
  localparam rnn_addr_t RNN_ADDR_VALID_STAT = 3'd0;
  localparam rnn_addr_t RNN_ADDR_DENSE      = 3'd7;
  localparam rnn_addr_t RNN_ADDR_RESULT     = 3'd7;

endpackage

// File: rtl/rnn_sequencer_if.sv
// Register bus between the sequencer (master) and the rnn accelerator (slave).
interface rnn_sequencer_if;
  import rnn_seq_pkg::*;

  logic        rnn_read;
  logic        rnn_write;
  rnn_addr_t   rnn_addr;
  logic [31:0] rnn_wdata;
  logic [31:0] rnn_rdata;

  modport master (output rnn_read, rnn_write, rnn_addr, rnn_wdata, input rnn_rdata);
  modport slave  (input rnn_read, rnn_write, rnn_addr, rnn_wdata, output rnn_rdata);
endinterface

// File: rtl/rnn_sequencer_sync_fifo.sv
// Show-ahead synchronous FIFO with a flush; depth must be a power of two.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full    = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}};
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/rnn_sequencer.sv
// Bus master that streams a whole embedding sequence into the rnn accelerator,
// triggers the dense layer and latches the scalar result.
module rnn_sequencer
  import rnn_seq_pkg::*;
#(
  parameter int EMB_LEN    = 4,
  parameter int FIFO_DEPTH = 64,
  parameter int TIMEOUT    = 1024,
  parameter int CHAR_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              emb_valid,
  output logic              emb_ready,
  input  logic [15:0]       emb_data,
  input  logic              start,
  input  logic [CHAR_W-1:0] num_chars,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       result,
  rnn_sequencer_if.master   bus
);
  localparam int TW = $clog2(TIMEOUT + 1);

  seq_state_e        state_q, state_d;
  logic [CHAR_W-1:0] char_cnt_q, char_cnt_d;
  logic [7:0]        elem_idx_q, elem_idx_d;
  logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic [15:0]       result_q, result_d;
  logic              busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic              read_q, read_d, write_q, write_d;
  rnn_addr_t         addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              fifo_pop, fifo_flush, fifo_full, fifo_empty, tmo_hit, rd_hit;
  logic [15:0]       fifo_dout;
  logic              unused_rdata;

  sync_fifo #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .flush(fifo_flush), .push(emb_valid), .pop(fifo_pop),
    .din(emb_data), .dout(fifo_dout), .full(fifo_full), .empty(fifo_empty)
  );

  assign emb_ready    = !fifo_full;
  assign unused_rdata = ^bus.rnn_rdata[31:16];
  assign tmo_hit      = (tmo_cnt_q == TW'(TIMEOUT - 1));
  // A poll succeeds on the registered read that is on the bus this cycle.
  assign rd_hit       = read_q && bus.rnn_rdata[0];

  always_comb begin
    state_d    = state_q;
    char_cnt_d = char_cnt_q;
    elem_idx_d = elem_idx_q;
    tmo_cnt_d  = '0;
    result_d   = result_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    read_d     = 1'b0;
    write_d    = 1'b0;
    addr_d     = '0;
    wdata_d    = '0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          char_cnt_d = num_chars;
          elem_idx_d = '0;
          state_d    = (num_chars == '0) ? ST_WR_DENSE : ST_WR_EMB;
        end
      end
      ST_WR_EMB: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          write_d    = 1'b1;
          addr_d     = RNN_ADDR_INPUT;
          wdata_d    = {8'h00, elem_idx_q, fifo_dout};
          elem_idx_d = elem_idx_q + 8'd1;
          if (elem_idx_q == 8'(EMB_LEN - 1)) begin
            elem_idx_d = '0;
            state_d    = ST_WR_START;
          end
        end
      end
      ST_WR_START: begin
        write_d = 1'b1;
        addr_d  = RNN_ADDR_START;
        state_d = ST_GAP;
      end
      ST_GAP: state_d = ST_WAIT_LOAD;
      ST_WAIT_LOAD: begin
        if (rd_hit) begin
          char_cnt_d = char_cnt_q - CHAR_W'(1);
          state_d    = (char_cnt_q != CHAR_W'(1)) ? ST_WR_EMB : ST_WR_DENSE;
        end else if (tmo_hit) begin
          error_d = 1'b1; fifo_flush = 1'b1; state_d = ST_IDLE;
        end else begin
          read_d = 1'b1; addr_d = RNN_ADDR_LOAD_STAT;
        end
      end
      ST_WR_DENSE: begin
        write_d = 1'b1;
        addr_d  = RNN_ADDR_DENSE;
        state_d = ST_WAIT_VALID;
      end
      ST_WAIT_VALID: begin
        if (rd_hit) begin
          state_d = ST_RD_RESULT;
        end else if (tmo_hit) begin
          error_d = 1'b1; fifo_flush = 1'b1; state_d = ST_IDLE;
        end else begin
          read_d = 1'b1; addr_d = RNN_ADDR_VALID_STAT;
        end
      end
      ST_RD_RESULT: begin
        read_d  = 1'b1;
        addr_d  = RNN_ADDR_RESULT;
        state_d = ST_WAIT_CLR;
      end
      ST_WAIT_CLR: begin
        // The result read lands on the first cycle here, ahead of the clear polls.
        if (read_q && addr_q == RNN_ADDR_RESULT) result_d = bus.rnn_rdata[15:0];
        if (rd_hit && addr_q == RNN_ADDR_LOAD_STAT) begin
          done_d = 1'b1; state_d = ST_IDLE;
        end else if (tmo_hit) begin
          error_d = 1'b1; fifo_flush = 1'b1; state_d = ST_IDLE;
        end else begin
          read_d = 1'b1; addr_d = RNN_ADDR_LOAD_STAT;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == state_q &&
        (state_q == ST_WAIT_LOAD || state_q == ST_WAIT_VALID || state_q == ST_WAIT_CLR))
      tmo_cnt_d = tmo_cnt_q + TW'(1);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      char_cnt_q <= '0;
      elem_idx_q <= '0;
      tmo_cnt_q  <= '0;
      result_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      char_cnt_q <= char_cnt_d;
      elem_idx_q <= elem_idx_d;
      tmo_cnt_q  <= tmo_cnt_d;
      result_q   <= result_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      read_q     <= read_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign result        = result_q;
  assign bus.rnn_read  = read_q;
  assign bus.rnn_write = write_q;
  assign bus.rnn_addr  = addr_q;
  assign bus.rnn_wdata = wdata_q;
endmodule
